// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, drives the instruction memory address and
// buffers returned words with their PC in a small FIFO feeding decode as a valid/ready stream.
module fetch_controller #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          PC_STEP  = 4,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc,
    input  logic        out_ready,
    output logic [31:0] fetch_count
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [63:0]       STEP     = 64'(PC_STEP);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FULL
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [63:0]        pc;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               push;
    logic               pop;
    logic [31:0]        inst_q [DEPTH];
    logic [63:0]        pc_q   [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, regardless of statement order inside the block.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational process gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = RUN;
        end else begin
            case (state)
                IDLE:      state_next = RUN;
                RUN, FULL: state_next = (count_next == FULL_CNT && !pop) ? FULL : RUN;
                default:   state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        pop        = out_valid && out_ready;
        push       = (state != IDLE) && !stall && !redirect_valid
                     && ((count < FULL_CNT) || pop);
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // NOTE: the FIFO storage is reset as well, because the head outputs read straight
    // from it and must show zero after reset; with only DEPTH entries this is cheap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc          <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fetch_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (redirect_valid) begin
            // A same-cycle pop was already consumed by decode; the flush discards the rest.
            pc     <= redirect_pc & ~64'h3;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                inst_q[wr_ptr] <= imem_inst;
                pc_q[wr_ptr]   <= pc;
                wr_ptr         <= wr_ptr + PTR_W'(1);
                pc             <= pc + STEP;
                fetch_count    <= fetch_count + 32'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

    assign imem_addr = pc;
    assign out_valid = (count != '0);
    assign out_inst  = inst_q[rd_ptr];
    assign out_pc    = pc_q[rd_ptr];

endmodule
